// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter.
//   arbState_t : FSM state encoding (IDLE = 0 ... D_WAIT = 4)
//   SIZE_*     : bus transfer size codes
//   PRIO_*     : encodings for the INST_PRIO tie-break parameter
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_WAIT = 3'd2,
    D_ADDR = 3'd3,
    D_WAIT = 3'd4
  } arbState_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int PRIO_DATA = 0;  // data wins a same-cycle tie
  localparam int PRIO_INST = 1;  // instruction wins a same-cycle tie

endpackage

// File: rtl/mem_arb_perf.sv
// Performance counters for the memory port arbiter (built only when
// MEM_ARB_PERF_EN is defined in the top).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   instOk/dataOk : completion pulses from the arbiter
//   memStall      : stall term driven to the hazard unit
//   perf*Cnt      : free-running 32-bit counters, wrap at 2^32
module mem_arb_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instOk,
  input  logic        dataOk,
  input  logic        memStall,
  output logic [31:0] perfInstCnt,
  output logic [31:0] perfDataCnt,
  output logic [31:0] perfStallCnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfInstCnt  <= '0;
      perfDataCnt  <= '0;
      perfStallCnt <= '0;
    end else begin
      if (instOk)   perfInstCnt  <= perfInstCnt + 32'd1;
      if (dataOk)   perfDataCnt  <= perfDataCnt + 32'd1;
      if (memStall) perfStallCnt <= perfStallCnt + 32'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one sram-like memory port between instruction fetch (IF) and
// load/store (MEM). One transaction outstanding at a time; read data is
// registered back to the requester with a one-cycle *_ok pulse.
// Optional feature macro: MEM_ARB_PERF_EN adds perf_inst_cnt,
// perf_data_cnt and perf_stall_cnt outputs.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   inst_*              : fetch request side (req/addr/flush in, rdata/ok out)
//   data_*              : load/store side (req/wr/size/addr/wdata in, rdata/ok out)
//   bus_*               : shared memory port (req/wr/size/addr/wdata out,
//                         addr_ok/data_ok/rdata in)
//   mem_stall           : stall term for the hazard unit
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int INST_PRIO = PRIO_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_flush,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ok,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       perf_inst_cnt,
  output logic [31:0]       perf_data_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic              mem_stall
);

  arbState_t         state;
  logic              discard;
  logic              busReqQ;
  logic              busWrQ;
  logic [1:0]        busSizeQ;
  logic [ADDR_W-1:0] busAddrQ;
  logic [DATA_W-1:0] busWdataQ;
  logic              instOkQ;
  logic              dataOkQ;
  logic [DATA_W-1:0] instRdataQ;
  logic [DATA_W-1:0] dataRdataQ;

  // A requester whose ok pulse is high this cycle is dropping its req, so
  // it must not be granted again on the stale level.
  logic instElig, dataElig, grantInst, grantData;
  assign instElig  = inst_req & ~instOkQ;
  assign dataElig  = data_req & ~dataOkQ;
  assign grantInst = instElig & (~dataElig | (INST_PRIO == PRIO_INST));
  assign grantData = dataElig & ~grantInst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      discard    <= 1'b0;
      busReqQ    <= 1'b0;
      busWrQ     <= 1'b0;
      busSizeQ   <= '0;
      busAddrQ   <= '0;
      busWdataQ  <= '0;
      instOkQ    <= 1'b0;
      dataOkQ    <= 1'b0;
      instRdataQ <= '0;
      dataRdataQ <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of the state and latched registers.
      instOkQ <= 1'b0;
      dataOkQ <= 1'b0;
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (grantInst) begin
            state     <= I_ADDR;
            busReqQ   <= 1'b1;
            busWrQ    <= 1'b0;
            busSizeQ  <= SIZE_WORD;
            busAddrQ  <= inst_addr;
            busWdataQ <= '0;
          end else if (grantData) begin
            state     <= D_ADDR;
            busReqQ   <= 1'b1;
            busWrQ    <= data_wr;
            busSizeQ  <= data_size;
            busAddrQ  <= data_addr;
            busWdataQ <= data_wdata;
          end
        end
        I_ADDR: begin
          // A flushed fetch still has to finish its address phase.
          if (inst_flush) discard <= 1'b1;
          if (bus_addr_ok) begin
            state   <= I_WAIT;
            busReqQ <= 1'b0;
          end
        end
        I_WAIT: begin
          if (bus_data_ok) begin
            state <= IDLE;
            if (!discard && !inst_flush) begin
              instRdataQ <= bus_rdata;
              instOkQ    <= 1'b1;
            end
          end else if (inst_flush) begin
            discard <= 1'b1;
          end
        end
        D_ADDR: begin
          if (bus_addr_ok) begin
            state   <= D_WAIT;
            busReqQ <= 1'b0;
          end
        end
        D_WAIT: begin
          if (bus_data_ok) begin
            state   <= IDLE;
            dataOkQ <= 1'b1;
            if (!busWrQ) dataRdataQ <= bus_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The slave must not complete a transfer in the same cycle it accepts it.
  addrDataOverlap: assert property (@(posedge clk) disable iff (!rst)
    (((state == I_ADDR) || (state == D_ADDR)) && bus_addr_ok) |-> !bus_data_ok);

  assign bus_req    = busReqQ;
  assign bus_wr     = busWrQ;
  assign bus_size   = busSizeQ;
  assign bus_addr   = busAddrQ;
  assign bus_wdata  = busWdataQ;
  assign inst_ok    = instOkQ;
  assign inst_rdata = instRdataQ;
  assign data_ok    = dataOkQ;
  assign data_rdata = dataRdataQ;
  assign mem_stall  = (inst_req & ~instOkQ) | (data_req & ~dataOkQ);

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf uPerf (
    .clk          (clk),
    .rst_n        (rst),
    .instOk       (instOkQ),
    .dataOk       (dataOkQ),
    .memStall     (mem_stall),
    .perfInstCnt  (perf_inst_cnt),
    .perfDataCnt  (perf_data_cnt),
    .perfStallCnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. The bench plays the memory
// slave; expected bus transactions, completion cycles, read data and stall
// cycle counts come from a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int TB_PRIO = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_flush, inst_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        mem_stall;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_inst_cnt, perf_data_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .INST_PRIO(TB_PRIO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
    .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ok(data_ok),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
`ifdef MEM_ARB_PERF_EN
    .perf_inst_cnt(perf_inst_cnt), .perf_data_cnt(perf_data_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .mem_stall(mem_stall)
  );

  int checks = 0;
  int errors = 0;

  // Model state carried across scenarios
  logic [31:0] expInstRd = '0;
  logic [31:0] expDataRd = '0;
  int perfInstExp = 0, perfDataExp = 0, perfStallExp = 0;

  // Slave state and per-transaction log
  int          sph, scnt, txnCnt;
  int          slvA [8];
  int          slvD [8];
  logic [31:0] slvR [8];
  logic        logWr [8];
  logic [1:0]  logSize [8];
  logic [31:0] logAddr [8];
  logic [31:0] logWdata [8];
  int          logAcyc [8];
  logic        logStable [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One cycle of slave behaviour, called right after the falling edge.
  task automatic slaveStep();
    int k;
    k = (txnCnt < 8) ? txnCnt : 7;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    if (sph == 0 && bus_req === 1'b1) begin
      logWr[k] = bus_wr; logSize[k] = bus_size;
      logAddr[k] = bus_addr; logWdata[k] = bus_wdata;
      logAcyc[k] = 0; logStable[k] = 1'b1;
      sph = 1; scnt = 0;
    end
    if (sph == 1) begin
      if (!(bus_req === 1'b1 && bus_wr === logWr[k] && bus_size === logSize[k] &&
            bus_addr === logAddr[k] && bus_wdata === logWdata[k]))
        logStable[k] = 1'b0;
      logAcyc[k]++;
      if (scnt == slvA[k]) begin
        bus_addr_ok = 1'b1; sph = 2; scnt = 0;
      end else scnt++;
    end else if (sph == 2) begin
      if (bus_req !== 1'b0) logStable[k] = 1'b0;
      if (scnt == slvD[k]) begin
        bus_data_ok = 1'b1; bus_rdata = slvR[k]; sph = 0; txnCnt++;
      end else scnt++;
    end
  endtask

  // Runs one request scenario from an idle arbiter. flushCyc < 0 means no
  // flush; with a flush the fetch address is redirected to iA2 from that cycle.
  task automatic scenario(input string tag, input logic doI, input logic [31:0] iA,
                          input logic [31:0] iA2, input logic doD, input logic dWr,
                          input logic [1:0] dSz, input logic [31:0] dA,
                          input logic [31:0] dWd, input int flushCyc,
                          input int a0, input int d0, input int a1, input int d1,
                          input logic [31:0] r0, input logic [31:0] r1);
    int nTx, iPos, dPos, iOkExp, dOkExp, lastOk;
    int okAt [2];
    logic expIsInst [2];
    logic [31:0] rsp [2];
    logic [31:0] newInst, newData;
    int iOkAt, dOkAt, iOkCnt, dOkCnt, stallSeen;
    logic iDone, dDone;

    okAt[0] = 3 + a0 + d0;
    okAt[1] = 6 + a0 + d0 + a1 + d1;
    rsp[0] = r0; rsp[1] = r1;
    iPos = -1; dPos = -1;
    if (flushCyc >= 0) begin
      nTx = 2; expIsInst[0] = 1'b1; expIsInst[1] = 1'b1; iPos = 1;
    end else if (doI && doD) begin
      nTx = 2;
      if (TB_PRIO == 1) begin expIsInst[0] = 1'b1; expIsInst[1] = 1'b0; iPos = 0; dPos = 1; end
      else              begin expIsInst[0] = 1'b0; expIsInst[1] = 1'b1; iPos = 1; dPos = 0; end
    end else begin
      nTx = 1; expIsInst[0] = doI; expIsInst[1] = 1'b0;
      if (doI) iPos = 0; else dPos = 0;
    end
    iOkExp = (iPos >= 0) ? okAt[iPos] : -1;
    dOkExp = (dPos >= 0) ? okAt[dPos] : -1;
    lastOk = (iOkExp > dOkExp) ? iOkExp : dOkExp;
    newInst = (iPos >= 0) ? rsp[iPos] : expInstRd;
    newData = (dPos >= 0 && !dWr) ? rsp[dPos] : expDataRd;

    for (int k = 0; k < 8; k++) begin
      slvA[k] = (k == 0) ? a0 : (k == 1) ? a1 : 0;
      slvD[k] = (k == 0) ? d0 : (k == 1) ? d1 : 0;
      slvR[k] = (k < 2) ? rsp[k] : 32'hBAD0_0000;
    end
    sph = 0; scnt = 0; txnCnt = 0;
    iOkAt = -1; dOkAt = -1; iOkCnt = 0; dOkCnt = 0; stallSeen = 0;
    iDone = 1'b0; dDone = 1'b0;

    for (int t = 0; t <= lastOk + 3; t++) begin
      @(negedge clk);
      inst_req   = doI && !iDone;
      inst_addr  = (flushCyc >= 0 && t >= flushCyc) ? iA2 : iA;
      inst_flush = (t == flushCyc);
      data_req   = doD && !dDone;
      data_wr = dWr; data_size = dSz; data_addr = dA; data_wdata = dWd;
      slaveStep();
      #1;
      check1({tag, " mem_stall"}, mem_stall, (inst_req & ~inst_ok) | (data_req & ~data_ok));
      if (mem_stall === 1'b1) stallSeen++;
      if (inst_ok === 1'b1) begin iOkCnt++; if (iOkAt < 0) iOkAt = t; iDone = 1'b1; end
      if (data_ok === 1'b1) begin dOkCnt++; if (dOkAt < 0) dOkAt = t; dDone = 1'b1; end
      if (flushCyc >= 0 && t == okAt[0])
        check({tag, " flushed rdata kept"}, inst_rdata, expInstRd);
    end
    inst_req = 1'b0; data_req = 1'b0; inst_flush = 1'b0;

    check({tag, " txn count"}, 32'(txnCnt), 32'(nTx));
    for (int k = 0; k < nTx && k < txnCnt; k++) begin
      check($sformatf("%s txn%0d addr", tag, k), logAddr[k],
            expIsInst[k] ? ((flushCyc >= 0 && k == 1) ? iA2 : iA) : dA);
      check1($sformatf("%s txn%0d wr", tag, k), logWr[k], expIsInst[k] ? 1'b0 : dWr);
      check($sformatf("%s txn%0d size", tag, k), 32'(logSize[k]), expIsInst[k] ? 32'd2 : 32'(dSz));
      if (!expIsInst[k]) check($sformatf("%s txn%0d wdata", tag, k), logWdata[k], dWd);
      check($sformatf("%s txn%0d req cycles", tag, k), 32'(logAcyc[k]), 32'(slvA[k] + 1));
      check1($sformatf("%s txn%0d bus stable", tag, k), logStable[k], 1'b1);
    end
    check({tag, " inst_ok cycle"}, 32'(iOkAt), 32'(iOkExp));
    check({tag, " data_ok cycle"}, 32'(dOkAt), 32'(dOkExp));
    check({tag, " inst_ok count"}, 32'(iOkCnt), 32'(iPos >= 0 ? 1 : 0));
    check({tag, " data_ok count"}, 32'(dOkCnt), 32'(dPos >= 0 ? 1 : 0));
    check({tag, " stall cycles"}, 32'(stallSeen), 32'(lastOk));
    check({tag, " inst_rdata"}, inst_rdata, newInst);
    check({tag, " data_rdata"}, data_rdata, newData);

    expInstRd = newInst;
    expDataRd = newData;
    perfInstExp += (iPos >= 0) ? 1 : 0;
    perfDataExp += (dPos >= 0) ? 1 : 0;
    perfStallExp += lastOk;
  endtask

  initial begin
    rst = 1'b0;
    inst_req = 0; inst_addr = 0; inst_flush = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check1("rst bus_req", bus_req, 1'b0);
    check1("rst inst_ok", inst_ok, 1'b0);
    check1("rst data_ok", data_ok, 1'b0);
    check("rst bus_addr", bus_addr, 32'h0);
    check("rst inst_rdata", inst_rdata, 32'h0);
    check("rst data_rdata", data_rdata, 32'h0);
    check1("rst mem_stall", mem_stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Minimum-latency fetch
    scenario("lat", 1'b1, 32'hBFC0_0000, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0,
             -1, 0, 0, 0, 0, 32'h3C08_BFAF, 32'h0);
    // Same-cycle tie: data wins, fetch follows
    scenario("tie", 1'b1, 32'hBFC0_0004, 32'h0, 1'b1, 1'b0, 2'd2, 32'h8000_1004, 32'h0,
             -1, 0, 0, 0, 0, 32'h1111_2222, 32'h3333_4444);
    // Halfword store with a slow address phase
    scenario("store", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 2'd1, 32'h8000_0002, 32'h0000_BEEF,
             -1, 4, 1, 0, 0, 32'hDEAD_DEAD, 32'h0);
    // Flush during I_WAIT, redirect to the exception vector
    scenario("flush", 1'b1, 32'hBFC0_0010, 32'hBFC0_0380, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0,
             3, 0, 2, 1, 0, 32'h0BAD_F00D, 32'h2400_0001);

    // Reset while a load sits in D_WAIT
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_2000;
    @(negedge clk);
    #1 check1("rstmid bus_req up", bus_req, 1'b1);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    #1 check1("rstmid in wait", bus_req, 1'b0);
    #1 rst = 1'b0;
    #1;
    check1("rstmid bus_req", bus_req, 1'b0);
    check("rstmid bus_addr", bus_addr, 32'h0);
    check("rstmid bus_size", 32'(bus_size), 32'h0);
    check1("rstmid data_ok", data_ok, 1'b0);
    check("rstmid inst_rdata", inst_rdata, 32'h0);
    check("rstmid data_rdata", data_rdata, 32'h0);
    check1("rstmid mem_stall", mem_stall, 1'b1);
    expInstRd = '0; expDataRd = '0;
    perfInstExp = 0; perfDataExp = 0; perfStallExp = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check1("rstmid regrant req", bus_req, 1'b1);
    check("rstmid regrant addr", bus_addr, 32'h8000_2000);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5A5A_A5A5;
    @(negedge clk);
    bus_data_ok = 1'b0;
    #1;
    check1("rstmid data_ok", data_ok, 1'b1);
    check("rstmid load data", data_rdata, 32'h5A5A_A5A5);
    data_req = 1'b0;
    expDataRd = 32'h5A5A_A5A5;
    perfDataExp = 1; perfStallExp = 3;

    // Randomized scenarios
    for (int n = 0; n < 24; n++) begin
      int mode, a0, d0, fc;
      logic doI, doD;
      mode = int'($urandom_range(0, 2));
      doI = (mode != 1);
      doD = (mode != 0);
      a0 = int'($urandom_range(0, 3));
      d0 = int'($urandom_range(0, 3));
      fc = (mode == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 + a0 + d0)) : -1;
      scenario($sformatf("rnd%0d", n), doI, $urandom, $urandom, doD,
               logic'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom,
               fc, a0, d0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $urandom, $urandom);
    end

`ifdef MEM_ARB_PERF_EN
    @(negedge clk);
    check("perf inst", perf_inst_cnt, 32'(perfInstExp));
    check("perf data", perf_data_cnt, 32'(perfDataExp));
    check("perf stall", perf_stall_cnt, 32'(perfStallExp));
`endif
    $display("model totals: fetches %0d loads/stores %0d stall cycles %0d",
             perfInstExp, perfDataExp, perfStallExp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
